// File: rtl/key_event_spi_pkg.sv
// key_event_spi_pkg: shared types, frame bit layout and frame builder
// for the key_event_spi keypad event reporter.
package key_event_spi_pkg;

    localparam int KEY_W_DEF = 4;
    localparam logic [KEY_W_DEF-1:0] NO_KEY_DEF = 4'hD;

    // One queued key event: release flag plus key code.
    typedef struct packed {
        logic                 rel;
        logic [KEY_W_DEF-1:0] code;
    } key_event_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_mode_t;

    function automatic int valid_bit(input int fw);
        return fw - 1;
    endfunction

    function automatic int ovf_bit(input int fw);
        return fw - 2;
    endfunction

    function automatic int rel_bit(input int fw);
        return fw - 3;
    endfunction

    // Frame: {valid, ovf, rel, 0.., code}; code is no_key when not valid.
    // Built 64 bits wide; callers cast down to their frame width.
    function automatic logic [63:0] build_frame(
        input int          fw,
        input int          kw,
        input logic        valid,
        input logic        ovf,
        input logic        rel,
        input logic [31:0] code,
        input logic [31:0] no_key
    );
        logic [63:0] mask;
        logic [63:0] f;
        mask = (64'd1 << kw) - 64'd1;
        f    = {32'd0, (valid ? code : no_key)} & mask;
        f    = f | (64'(valid) << valid_bit(fw))
                 | (64'(ovf)   << ovf_bit(fw))
                 | (64'(rel)   << rel_bit(fw));
        return f;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous event FIFO on sclk with async active-high reset.
// Ports: push/din write, pop read, full/empty/level status, head entry and
// the entry behind it (second), used to reload back-to-back frames.
module key_event_fifo
    import key_event_spi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                       sclk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [W-1:0]               head,
    output logic [W-1:0]               second
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign second  = mem[inc(rd_ptr)];

    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/key_event_spi.sv
// key_event_spi: SPI slave reporting keypad press (and optionally release,
// macro KEY_EVENT_SPI_RELEASE_EN) events as a FIFO of FRAME_W-bit frames.
// Ports: sclk/reset, cs_n/sdi/sdo SPI, key_code/key_down from the debouncer,
// rx_data/rx_valid received frame, fifo_level and sticky overflow status.
module key_event_spi
    import key_event_spi_pkg::*;
#(
    parameter int               KEY_W   = KEY_W_DEF,
    parameter int               FRAME_W = 8,
    parameter int               DEPTH   = 4,
    parameter logic [KEY_W-1:0] NO_KEY  = KEY_W'(NO_KEY_DEF)
) (
    input  logic                       sclk,
    input  logic                       reset,
    input  logic                       cs_n,
    input  logic                       sdi,
    input  logic [KEY_W-1:0]           key_code,
    input  logic                       key_down,
    output logic                       sdo,
    output logic [FRAME_W-1:0]         rx_data,
    output logic                       rx_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(FRAME_W);
`ifdef KEY_EVENT_SPI_RELEASE_EN
    localparam int EW = KEY_W + 1;
`else
    localparam int EW = KEY_W;
`endif

    logic               prev_down;
    logic [KEY_W-1:0]   prev_code;
    logic               press;
    logic               push;
    logic [EW-1:0]      din;
    logic [EW-1:0]      head;
    logic [EW-1:0]      second;
    logic               full;
    logic               empty;

    shift_mode_t        mode;
    logic [FRAME_W-1:0] sh;
    logic [FRAME_W-1:0] sh_n;
    logic [FRAME_W-1:0] shifted;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic               txv;
    logic               txv_n;
    logic               txo;
    logic               txo_n;
    logic               done;
    logic               pop;
    logic               drop;
    logic               ovf_n;
    logic [EW-1:0]      ld_ent;
    logic               ld_v;
    logic               ld_o;
    logic               ld_rel;
    logic [FRAME_W-1:0] ld_frame;

    // Event detection: new press on key-down edge or code change while held.
    assign press = key_down & (~prev_down | (key_code != prev_code));

`ifdef KEY_EVENT_SPI_RELEASE_EN
    logic rel_ev;
    assign rel_ev = ~key_down & prev_down;
    assign push   = press | rel_ev;
    assign din    = rel_ev ? {1'b1, prev_code} : {1'b0, key_code};
    assign ld_rel = ld_ent[KEY_W];
`else
    assign push   = press;
    assign din    = key_code;
    assign ld_rel = 1'b0;
`endif

    // prev_code holds the last held code so a release reports it.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            prev_down <= 1'b0;
            prev_code <= '0;
        end else begin
            prev_down <= key_down;
            if (key_down) begin
                prev_code <= key_code;
            end
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .sclk   (sclk),
        .reset  (reset),
        .push   (push),
        .din    (din),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level),
        .head   (head),
        .second (second)
    );

    assign mode    = cs_n ? IDLE : SHIFT;
    assign shifted = {sh[FRAME_W-2:0], sdi};
    assign done    = (mode == SHIFT) && (cnt == CW'(FRAME_W - 1));
    assign pop     = done & txv;
    assign drop    = push & full & ~pop;
    // Set wins over the clear carried by a completed frame.
    assign ovf_n   = drop | (overflow & ~(done & txo));

    // Reload source: after a popping frame the new head is the second entry;
    // events pushed on this edge reach the frame after that.
    always_comb begin
        ld_ent = head;
        ld_v   = ~empty;
        ld_o   = overflow;
        if (pop) begin
            ld_ent = second;
            ld_v   = (fifo_level > LW'(1));
        end
        if (done) begin
            ld_o = ovf_n;
        end
    end

    assign ld_frame = FRAME_W'(build_frame(
        FRAME_W, KEY_W, ld_v, ld_o, ld_rel,
        32'(ld_ent[KEY_W-1:0]), 32'(NO_KEY)));

    always_comb begin
        sh_n  = sh;
        cnt_n = cnt;
        txv_n = txv;
        txo_n = txo;
        unique case (mode)
            IDLE: begin
                sh_n  = ld_frame;
                cnt_n = '0;
                txv_n = ld_v;
                txo_n = ld_o;
            end
            SHIFT: begin
                if (done) begin
                    sh_n  = ld_frame;
                    cnt_n = '0;
                    txv_n = ld_v;
                    txo_n = ld_o;
                end else begin
                    sh_n  = shifted;
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            sh       <= '0;
            cnt      <= '0;
            txv      <= 1'b0;
            txo      <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sh       <= sh_n;
            cnt      <= cnt_n;
            txv      <= txv_n;
            txo      <= txo_n;
            rx_valid <= done;
            overflow <= ovf_n;
            if (done) begin
                rx_data <= shifted;
            end
        end
    end

    always_ff @(negedge sclk or posedge reset) begin
        if (reset) begin
            sdo <= 1'b0;
        end else begin
            sdo <= sh[FRAME_W-1];
        end
    end

endmodule
